count_checker: RTL and testbench

Passive checker that observes the `count` and `enable` outputs of a `WIDTH`-bit up-counter, on the same clock. It predicts the next count value and flags any deviation. It also reports lock status, wrap events and a saturating error count. It sits beside the counter in benches and in integration as a self-check monitor, and never drives the counter.

---
 rtl/count_checker_if.sv | 26 ++
 rtl/count_checker.sv | 114 +++++++++++
 tb/tb_count_checker.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/count_checker_if.sv
// Observation bus between a WIDTH-bit up-counter and its count_checker.
// The counter side (master) drives enable/count; the checker (slave)
// returns its lock/error/wrap status and its current prediction.
interface count_checker_if #(
   parameter int WIDTH     = 4,
   parameter int ERR_CNT_W = 8
);
   logic                 enable;
   logic [WIDTH-1:0]     count;
   logic                 locked;
   logic                 error;
   logic                 err_sticky;
   logic [ERR_CNT_W-1:0] err_count;
   logic                 wrap;
   logic [WIDTH-1:0]     expected;

   modport master (
      output enable, count,
      input  locked, error, err_sticky, err_count, wrap, expected
   );

   modport slave (
      input  enable, count,
      output locked, error, err_sticky, err_count, wrap, expected
   );
endinterface

// File: rtl/count_checker.sv
// count_checker: passive monitor for a WIDTH-bit up-counter.
// Predicts count(n+1) = count(n) + enable(n) mod 2^WIDTH and flags any
// deviation. It reports lock status, wrap events and a saturating error count.
// Optional feature macro: COUNT_CHECKER_ZERO_START_EN. When it is defined, the
// first sample after reset release must be zero.
module count_checker #(
   parameter int WIDTH         = 4,
   parameter int ERR_CNT_W     = 8,
   parameter int RESYNC_ON_ERR = 1
) (
   input logic             clk,
   input logic             rst,
   count_checker_if.slave  bus
);

   typedef enum logic {SYNC, TRACK} state_t;

   state_t               state;
   logic [WIDTH-1:0]     prev_count;
   logic                 prev_en;
   logic [WIDTH-1:0]     expected_q;
   logic                 locked_q;
   logic                 error_q;
   logic                 sticky_q;
   logic                 wrap_q;
   logic [ERR_CNT_W-1:0] err_cnt_q;
   logic                 mismatch;
   logic                 wrap_hit;
`ifdef COUNT_CHECKER_ZERO_START_EN
   logic                 first_q;
`endif

   // Classify the current sample: a mismatch is an error, and a correct max->0 step is a wrap
   always_comb begin
      mismatch = 1'b0;
      wrap_hit = 1'b0;
      case (state)
         SYNC: begin
`ifdef COUNT_CHECKER_ZERO_START_EN
            mismatch = first_q && (bus.count != '0);
`endif
         end
         TRACK: begin
            if (bus.count != expected_q) begin
               mismatch = 1'b1;
            end else begin
               wrap_hit = (prev_count == '1) && prev_en && (bus.count == '0);
            end
         end
         default: begin
            mismatch = 1'b0;
         end
      endcase
   end

   // Checker FSM, prediction pipeline and registered status outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= SYNC;
         prev_count <= '0;
         prev_en    <= 1'b0;
         expected_q <= '0;
         locked_q   <= 1'b0;
         error_q    <= 1'b0;
         sticky_q   <= 1'b0;
         wrap_q     <= 1'b0;
         err_cnt_q  <= '0;
`ifdef COUNT_CHECKER_ZERO_START_EN
         first_q    <= 1'b1;
`endif
      end else begin
         // The prediction always restarts from the observed value, so the
         // no-resync mode needs no separate recovery path.
         prev_count <= bus.count;
         prev_en    <= bus.enable;
         expected_q <= bus.count + WIDTH'(bus.enable);
         error_q    <= mismatch;
         wrap_q     <= wrap_hit;
         if (mismatch) begin
            sticky_q <= 1'b1;
            if (err_cnt_q != '1) begin
               err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
            end
         end
         case (state)
            SYNC: begin
               state    <= TRACK;
               locked_q <= 1'b1;
`ifdef COUNT_CHECKER_ZERO_START_EN
               first_q  <= 1'b0;
`endif
            end
            TRACK: begin
               if (mismatch && (RESYNC_ON_ERR != 0)) begin
                  state    <= SYNC;
                  locked_q <= 1'b0;
               end
            end
            default: begin
               state    <= SYNC;
               locked_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.locked     = locked_q;
   assign bus.error      = error_q;
   assign bus.err_sticky = sticky_q;
   assign bus.err_count  = err_cnt_q;
   assign bus.wrap       = wrap_q;
   assign bus.expected   = expected_q;

endmodule

// File: tb/tb_count_checker.sv
// Bench for count_checker. Two instances observe the same counter stimulus.
// Instance A uses the defaults (RESYNC_ON_ERR=1, ERR_CNT_W=8).
// Instance B uses RESYNC_ON_ERR=0 and ERR_CNT_W=2.
module tb_count_checker;

   logic clk;
   logic rst;

   count_checker_if #(.WIDTH(4), .ERR_CNT_W(8)) bus_a ();
   count_checker_if #(.WIDTH(4), .ERR_CNT_W(2)) bus_b ();

   count_checker #(.WIDTH(4), .ERR_CNT_W(8), .RESYNC_ON_ERR(1)) u_dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a)
   );

   count_checker #(.WIDTH(4), .ERR_CNT_W(2), .RESYNC_ON_ERR(0)) u_dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model: one entry per instance (0 = A, 1 = B)
   bit m_trk    [2];
   bit m_first  [2];
   int m_pred   [2];
   int m_pc     [2];
   int m_pe     [2];
   bit m_sticky [2];
   bit m_err    [2];
   bit m_wrap   [2];
   int m_ecnt   [2];
   int m_cap    [2] = '{255, 3};
   bit m_resync [2] = '{1'b1, 1'b0};

   int cnt;
   int obs_err_a, obs_err_b, obs_wrap_a;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_trk[k] = 0; m_first[k] = 1; m_pred[k] = 0; m_pc[k] = 0; m_pe[k] = 0;
         m_sticky[k] = 0; m_err[k] = 0; m_wrap[k] = 0; m_ecnt[k] = 0;
      end
   endtask

   task automatic model_step(input int c, input int e);
      for (int k = 0; k < 2; k++) begin
         bit err;
         bit wr;
         err = 0;
         wr  = 0;
         if (!m_trk[k]) begin
`ifdef COUNT_CHECKER_ZERO_START_EN
            if (m_first[k] && c != 0) err = 1;
`endif
            m_trk[k]   = 1;
            m_first[k] = 0;
         end else if (c != m_pred[k]) begin
            err = 1;
            if (m_resync[k]) m_trk[k] = 0;
         end else if (m_pc[k] == 15 && m_pe[k] == 1 && c == 0) begin
            wr = 1;
         end
         if (err) begin
            m_sticky[k] = 1;
            if (m_ecnt[k] < m_cap[k]) m_ecnt[k]++;
         end
         m_err[k]  = err;
         m_wrap[k] = wr;
         m_pred[k] = (c + e) % 16;
         m_pc[k]   = c;
         m_pe[k]   = e;
      end
   endtask

   task automatic check_all();
      chk("A.locked",     32'(bus_a.locked),     32'(m_trk[0]));
      chk("A.error",      32'(bus_a.error),      32'(m_err[0]));
      chk("A.err_sticky", 32'(bus_a.err_sticky), 32'(m_sticky[0]));
      chk("A.err_count",  32'(bus_a.err_count),  32'(m_ecnt[0]));
      chk("A.wrap",       32'(bus_a.wrap),       32'(m_wrap[0]));
      chk("A.expected",   32'(bus_a.expected),   32'(m_pred[0]));
      chk("B.locked",     32'(bus_b.locked),     32'(m_trk[1]));
      chk("B.error",      32'(bus_b.error),      32'(m_err[1]));
      chk("B.err_sticky", 32'(bus_b.err_sticky), 32'(m_sticky[1]));
      chk("B.err_count",  32'(bus_b.err_count),  32'(m_ecnt[1]));
      chk("B.wrap",       32'(bus_b.wrap),       32'(m_wrap[1]));
      chk("B.expected",   32'(bus_b.expected),   32'(m_pred[1]));
   endtask

   task automatic drive(input int c, input int e);
      bus_a.count  = 4'(c);
      bus_a.enable = e[0];
      bus_b.count  = 4'(c);
      bus_b.enable = e[0];
   endtask

   // One observed sample: drive, clock, step the model, check #1 after the edge
   task automatic cycle(input int c, input int e);
      drive(c, e);
      @(posedge clk);
      model_step(c, e);
      #1;
      check_all();
      obs_err_a  += int'(bus_a.error);
      obs_err_b  += int'(bus_b.error);
      obs_wrap_a += int'(bus_a.wrap);
   endtask

   task automatic good(input int e);
      cycle(cnt, e);
      cnt = (cnt + e) % 16;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      model_reset();
      #1;
      check_all();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      @(negedge clk);
      rst = 1'b1;
      cnt = 0;
      obs_err_a = 0; obs_err_b = 0; obs_wrap_a = 0;
   endtask

   initial begin
      rst = 1'b0;
      drive(0, 0);
      model_reset();

      // Phase 1: free-running correct counter, 20 cycles, one wrap expected
      do_reset();
      good(1);
      chk("p1.locked_2nd_cycle", 32'(bus_a.locked), 32'd1);
      for (int i = 1; i < 20; i++) good(1);
      chk("p1.wraps",     32'(obs_wrap_a),      32'd1);
      chk("p1.errors",    32'(obs_err_a),       32'd0);
      chk("p1.err_count", 32'(bus_a.err_count), 32'd0);

      // Phase 2: enable toggled every 3 cycles, counter holds and increments
      obs_err_a = 0; obs_err_b = 0;
      for (int i = 0; i < 18; i++) good((i / 3) % 2);
      chk("p2.errors_a", 32'(obs_err_a), 32'd0);
      chk("p2.errors_b", 32'(obs_err_b), 32'd0);

      // Phase 3: 5 -> 7 jump, resync in A, no resync in B
      do_reset();
      for (int i = 0; i < 6; i++) good(1);
      cycle(7, 1);
      cnt = 8;
      chk("p3.error",      32'(bus_a.error),      32'd1);
      chk("p3.err_sticky", 32'(bus_a.err_sticky), 32'd1);
      chk("p3.err_count",  32'(bus_a.err_count),  32'd1);
      chk("p3.unlocked",   32'(bus_a.locked),     32'd0);
      good(1);
      chk("p3.relocked",   32'(bus_a.locked),     32'd1);
      for (int i = 0; i < 5; i++) good(1);
      chk("p3.total_err_a", 32'(obs_err_a), 32'd1);

      // Phase 4: five consecutive bad values; B saturates at 3 and stays locked
      do_reset();
      for (int i = 0; i < 6; i++) good(1);
      begin
         int bad [5] = '{9, 2, 12, 3, 14};
         for (int i = 0; i < 5; i++) begin
            cycle(bad[i], 1);
            chk("p4.b_error",  32'(bus_b.error),  32'd1);
            chk("p4.b_locked", 32'(bus_b.locked), 32'd1);
         end
      end
      chk("p4.b_err_count", 32'(bus_b.err_count), 32'd3);
      chk("p4.b_pulses",    32'(obs_err_b),       32'd5);
      chk("p4.a_pulses",    32'(obs_err_a),       32'd3);

      // Phase 5: asynchronous reset mid-cycle right after an error
      cycle(0, 1);
      #2;
      rst = 1'b0;
      model_reset();
      #1;
      check_all();
      chk("p5.sticky_clr", 32'(bus_a.err_sticky), 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // Phase 6: first sample after release is nonzero (9)
      cnt = 9;
      obs_err_a = 0; obs_err_b = 0;
      good(1);
`ifdef COUNT_CHECKER_ZERO_START_EN
      chk("p6.first_error", 32'(bus_a.error),     32'd1);
      chk("p6.first_count", 32'(bus_a.err_count), 32'd1);
`else
      chk("p6.first_error", 32'(bus_a.error),     32'd0);
      chk("p6.first_count", 32'(bus_a.err_count), 32'd0);
`endif
      for (int i = 0; i < 8; i++) good(1);
      chk("p6.locked", 32'(bus_a.locked), 32'd1);

      // Phase 7: randomized enable with occasional injected faults
      for (int i = 0; i < 400; i++) begin
         int e;
         int c;
         e = int'($urandom_range(0, 1));
         c = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) : cnt;
         cycle(c, e);
         cnt = (c + e) % 16;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
